baw_game_ctrl: RTL and testbench
================================

// Module: baw_game_ctrl
// PURPOSE
//   Round sequencer for the black-and-white card game. Turns raw button levels into one-shot
//   commands and walks the init/ready/card-entry/match/result flow. It latches each player's
//   one-hot card choice, tracks used cards, and scores every round. It drives the comparator,
//   score and display paths inside baw_main, with round/win/lose/fin as the single source of truth.
// PARAMETERS
//   NUM_CARDS   9  cards per player (values 0..NUM_CARDS-1); also the maximum round count
//   WIN_TARGET  5  wins (or losses) for player 1 that end the game early
// PORTS
//   clk           in   1   system clock
//   reset         in   1   asynchronous, active-high reset
//   btnCenter/btnTop/btnBottom/btnLeft/btnRight  in  1 each  debounced, clk-synchronous levels
//   sw            in   16  card select; only sw[NUM_CARDS-1:0] used, must be one-hot
//   state         out  3   0 INIT,1 RASP,2 BAWP,3 P1_TURN,4 P2_TURN,5 MATCH,6 GAME
//   p1_card       out  4   latched p1 card value
//   p2_card       out  4   latched p2 card value
//   p1_valid      out  1   p1 card committed this round
//   p2_valid      out  1   p2 card committed this round
//   p1_used       out  9   used-card masks, bit k = card k spent
//   p2_used       out  9   used-card masks, bit k = card k spent
//   matchresult   out  2   01 p1 win, 10 p1 lose, 11 draw, 00 none
//   round         out  4   completed rounds
//   win           out  4   p1 round wins
//   lose          out  4   p1 round losses
//   fin           out  1   game over: win==WIN_TARGET | lose==WIN_TARGET | round==NUM_CARDS
//   scoreupdate_pulse  out  1  one-cycle pulse on the MATCH entry edge
//   gameresult    out  2   in GAME: 01 win>lose, 10 lose>win, 11 equal; else 00
// BEHAVIOUR
//   Reset (async): state=INIT; all outputs, masks and counters 0; button history regs 0.
//   Button edge: cmd = btn & ~btn_q (btn_q = previous-cycle level).
//     The state changes on the edge after the first high cycle (1-cycle latency).
//     A held button yields exactly one command.
//   Same-cycle commands priority: Bottom > Center > Top > Left > Right; lower ones are dropped.
//   Bottom, any state -> INIT, clearing cards, masks and counters (soft reset).
//   INIT    Center -> RASP.
//   RASP    Top -> BAWP.
//   BAWP    Left -> P1_TURN; Right -> P2_TURN.
//           Center -> MATCH only if p1_valid & p2_valid, else ignored.
//   P1_TURN Top -> BAWP. If sw[8:0] is one-hot at index k and p1_used[k]==0: p1_card=k, p1_valid=1.
//           Otherwise p1_card/p1_valid are unchanged. Re-entry may overwrite an earlier choice.
//   P2_TURN same rule as P1_TURN, using the p2 registers.
//   MATCH entry edge, all registered together:
//     matchresult from p1_card vs p2_card (greater wins, equal = 11).
//     win/lose incremented as applicable; round += 1.
//     p1_used[p1_card] = 1 and p2_used[p2_card] = 1.
//     scoreupdate_pulse = 1 for this cycle only.
//   fin is combinational from the counters, so it is valid the cycle after MATCH entry.
//   MATCH   Left -> GAME if fin, else RASP. On the RASP path: p1_valid=p2_valid=0, matchresult=00.
//   GAME    holds all counters; only Bottom leaves.
//   Counters never exceed NUM_CARDS and never wrap. Commands not listed for a state are ignored.
//   sw is sampled only on the Top edge in P1_TURN/P2_TURN.
// TESTING
//   T1 Reset mid-game: assert reset in P2_TURN at round=3 -> next sample state=0, round/win/lose=0,
//      masks=0, scoreupdate_pulse=0.
//   T2 Early win: 5 rounds with p1 card 8-i vs p2 card i-? such that p1 > p2 each time ->
//      win=5, fin=1 after round 5; Left -> state=6, gameresult=01.
//   T3 Full draw: 9 rounds, equal cards 0..8 -> matchresult=11 each round, round=9, win=lose=0,
//      fin=1, gameresult=11.
//   T4 Invalid entry: sw=0x0003, sw=0x0000, or a re-used card index -> p1_valid stays 0,
//      p1_used unchanged, state returns to BAWP.
//   T5 Guarded match: Center in BAWP with only p1_valid=1 -> state stays 2, round unchanged,
//      no scoreupdate_pulse.
//   T6 Priority/hold: Top+Left high together in P1_TURN held 5 cycles -> a single move to BAWP,
//      no P1_TURN re-entry. Bottom+Center together in MATCH -> INIT.

Source files
------------

// File: rtl/baw_game_ctrl_if.sv
// Button/switch inputs and status outputs of the black-and-white round sequencer.
// master drives buttons and switches; slave is the controller.
interface baw_game_ctrl_if #(
  parameter int NUM_CARDS = 9
);
  logic                 btnCenter;
  logic                 btnTop;
  logic                 btnBottom;
  logic                 btnLeft;
  logic                 btnRight;
  logic [15:0]          sw;
  logic [2:0]           state;
  logic [3:0]           p1_card;
  logic [3:0]           p2_card;
  logic                 p1_valid;
  logic                 p2_valid;
  logic [NUM_CARDS-1:0] p1_used;
  logic [NUM_CARDS-1:0] p2_used;
  logic [1:0]           matchresult;
  logic [3:0]           round;
  logic [3:0]           win;
  logic [3:0]           lose;
  logic                 fin;
  logic                 scoreupdate_pulse;
  logic [1:0]           gameresult;

  modport master (
    output btnCenter, btnTop, btnBottom, btnLeft, btnRight, sw,
    input  state, p1_card, p2_card, p1_valid, p2_valid, p1_used, p2_used,
           matchresult, round, win, lose, fin, scoreupdate_pulse, gameresult
  );

  modport slave (
    input  btnCenter, btnTop, btnBottom, btnLeft, btnRight, sw,
    output state, p1_card, p2_card, p1_valid, p2_valid, p1_used, p2_used,
           matchresult, round, win, lose, fin, scoreupdate_pulse, gameresult
  );
endinterface

// File: rtl/baw_game_ctrl.sv
// Round sequencer for the black-and-white card game: button one-shots, card entry,
// per-round scoring and game-over detection.
module baw_game_ctrl #(
  parameter int NUM_CARDS  = 9,
  parameter int WIN_TARGET = 5
) (
  input  logic           clk,
  input  logic           reset,
  baw_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_RASP    = 3'd1,
    ST_BAWP    = 3'd2,
    ST_P1_TURN = 3'd3,
    ST_P2_TURN = 3'd4,
    ST_MATCH   = 3'd5,
    ST_GAME    = 3'd6
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(NUM_CARDS);
  localparam logic [3:0] WIN_CNT = 4'(WIN_TARGET);

  state_t               state_q, state_d;
  logic [4:0]           btn_q, btn_lvl, cmd;
  logic [3:0]           p1_card_q, p1_card_d, p2_card_q, p2_card_d;
  logic                 p1_valid_q, p1_valid_d, p2_valid_q, p2_valid_d;
  logic [NUM_CARDS-1:0] p1_used_q, p1_used_d, p2_used_q, p2_used_d;
  logic [1:0]           matchresult_q, matchresult_d;
  logic [3:0]           round_q, round_d, win_q, win_d, lose_q, lose_d;
  logic                 pulse_q, pulse_d;
  logic                 cmd_bottom, cmd_center, cmd_top, cmd_left, cmd_right;
  logic [NUM_CARDS-1:0] sel;
  logic                 sel_onehot;
  logic [3:0]           sel_idx;
  logic                 fin_w;
  logic                 unused_sw_hi;

  assign btn_lvl = {bus.btnBottom, bus.btnCenter, bus.btnTop, bus.btnLeft, bus.btnRight};
  assign cmd     = btn_lvl & ~btn_q;

  // Only the highest-priority new press survives in a given cycle.
  assign cmd_bottom = cmd[4];
  assign cmd_center = cmd[3] & ~cmd[4];
  assign cmd_top    = cmd[2] & ~(|cmd[4:3]);
  assign cmd_left   = cmd[1] & ~(|cmd[4:2]);
  assign cmd_right  = cmd[0] & ~(|cmd[4:1]);

  assign sel          = bus.sw[NUM_CARDS-1:0];
  assign sel_onehot   = $onehot(sel);
  assign unused_sw_hi = ^bus.sw[15:NUM_CARDS];

  always_comb begin
    sel_idx = 4'd0;
    for (int k = 0; k < NUM_CARDS; k++) begin
      if (sel[k]) sel_idx = 4'(k);
    end
  end

  assign fin_w = (win_q == WIN_CNT) | (lose_q == WIN_CNT) | (round_q == MAX_CNT);

  always_comb begin
    state_d       = state_q;
    p1_card_d     = p1_card_q;
    p2_card_d     = p2_card_q;
    p1_valid_d    = p1_valid_q;
    p2_valid_d    = p2_valid_q;
    p1_used_d     = p1_used_q;
    p2_used_d     = p2_used_q;
    matchresult_d = matchresult_q;
    round_d       = round_q;
    win_d         = win_q;
    lose_d        = lose_q;
    pulse_d       = 1'b0;

    if (cmd_bottom) begin
      state_d       = ST_INIT;
      p1_card_d     = '0;
      p2_card_d     = '0;
      p1_valid_d    = 1'b0;
      p2_valid_d    = 1'b0;
      p1_used_d     = '0;
      p2_used_d     = '0;
      matchresult_d = '0;
      round_d       = '0;
      win_d         = '0;
      lose_d        = '0;
    end else begin
      unique case (state_q)
        ST_INIT: if (cmd_center) state_d = ST_RASP;
        ST_RASP: if (cmd_top) state_d = ST_BAWP;
        ST_BAWP: begin
          if (cmd_left) begin
            state_d = ST_P1_TURN;
          end else if (cmd_right) begin
            state_d = ST_P2_TURN;
          end else if (cmd_center && p1_valid_q && p2_valid_q) begin
            // Scoring happens on the entry edge so fin is valid one cycle later.
            state_d = ST_MATCH;
            pulse_d = 1'b1;
            if (p1_card_q > p2_card_q) begin
              matchresult_d = 2'b01;
              if (win_q < MAX_CNT) win_d = win_q + 4'd1;
            end else if (p1_card_q < p2_card_q) begin
              matchresult_d = 2'b10;
              if (lose_q < MAX_CNT) lose_d = lose_q + 4'd1;
            end else begin
              matchresult_d = 2'b11;
            end
            if (round_q < MAX_CNT) round_d = round_q + 4'd1;
            p1_used_d[p1_card_q] = 1'b1;
            p2_used_d[p2_card_q] = 1'b1;
          end
        end
        ST_P1_TURN: begin
          if (cmd_top) begin
            state_d = ST_BAWP;
            if (sel_onehot && ((sel & p1_used_q) == '0)) begin
              p1_card_d  = sel_idx;
              p1_valid_d = 1'b1;
            end
          end
        end
        ST_P2_TURN: begin
          if (cmd_top) begin
            state_d = ST_BAWP;
            if (sel_onehot && ((sel & p2_used_q) == '0)) begin
              p2_card_d  = sel_idx;
              p2_valid_d = 1'b1;
            end
          end
        end
        ST_MATCH: begin
          if (cmd_left) begin
            if (fin_w) begin
              state_d = ST_GAME;
            end else begin
              state_d       = ST_RASP;
              p1_valid_d    = 1'b0;
              p2_valid_d    = 1'b0;
              matchresult_d = 2'b00;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      btn_q         <= '0;
      p1_card_q     <= '0;
      p2_card_q     <= '0;
      p1_valid_q    <= 1'b0;
      p2_valid_q    <= 1'b0;
      p1_used_q     <= '0;
      p2_used_q     <= '0;
      matchresult_q <= '0;
      round_q       <= '0;
      win_q         <= '0;
      lose_q        <= '0;
      pulse_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn_lvl;
      p1_card_q     <= p1_card_d;
      p2_card_q     <= p2_card_d;
      p1_valid_q    <= p1_valid_d;
      p2_valid_q    <= p2_valid_d;
      p1_used_q     <= p1_used_d;
      p2_used_q     <= p2_used_d;
      matchresult_q <= matchresult_d;
      round_q       <= round_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      pulse_q       <= pulse_d;
    end
  end

  assign bus.state             = state_q;
  assign bus.p1_card           = p1_card_q;
  assign bus.p2_card           = p2_card_q;
  assign bus.p1_valid          = p1_valid_q;
  assign bus.p2_valid          = p2_valid_q;
  assign bus.p1_used           = p1_used_q;
  assign bus.p2_used           = p2_used_q;
  assign bus.matchresult       = matchresult_q;
  assign bus.round             = round_q;
  assign bus.win               = win_q;
  assign bus.lose              = lose_q;
  assign bus.fin               = fin_w;
  assign bus.scoreupdate_pulse = pulse_q;
  assign bus.gameresult        = (state_q != ST_GAME) ? 2'b00 :
                                 (win_q > lose_q)     ? 2'b01 :
                                 (lose_q > win_q)     ? 2'b10 : 2'b11;

endmodule

// File: tb/tb_baw_game_ctrl.sv
// Self-checking bench for baw_game_ctrl: match results are predicted into a queue when
// Center is pressed and compared when the score-update pulse appears.
module tb_baw_game_ctrl;

  localparam logic [4:0] B_BOTTOM = 5'b10000;
  localparam logic [4:0] B_CENTER = 5'b01000;
  localparam logic [4:0] B_TOP    = 5'b00100;
  localparam logic [4:0] B_LEFT   = 5'b00010;
  localparam logic [4:0] B_RIGHT  = 5'b00001;

  typedef struct {
    int mr;
    int rnd;
    int w;
    int l;
    int p1u;
    int p2u;
  } exp_t;

  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;
  exp_t sbQueue[$];
  exp_t sbItem;
  int   expRound, expWin, expLose, expP1Used, expP2Used;

  baw_game_ctrl_if #(.NUM_CARDS(9)) bus();

  baw_game_ctrl #(.NUM_CARDS(9), .WIN_TARGET(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive a button pattern for 'hold' cycles, release, and settle one more cycle.
  task automatic applyStimulus(input logic [4:0] btns, input int hold);
    @(negedge clk);
    {bus.btnBottom, bus.btnCenter, bus.btnTop, bus.btnLeft, bus.btnRight} = btns;
    repeat (hold) @(negedge clk);
    {bus.btnBottom, bus.btnCenter, bus.btnTop, bus.btnLeft, bus.btnRight} = 5'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] btns);
    applyStimulus(btns, 1);
  endtask

  task automatic setSwitch(input int value);
    bus.sw = 16'(value);
  endtask

  task automatic resetModel();
    expRound  = 0;
    expWin    = 0;
    expLose   = 0;
    expP1Used = 0;
    expP2Used = 0;
    sbQueue.delete();
  endtask

  // Enter a card for one player from BAWP; ends back in BAWP.
  task automatic enterCard(input logic [4:0] playerBtn, input int swValue);
    press(playerBtn);
    setSwitch(swValue);
    press(B_TOP);
    setSwitch(0);
  endtask

  // Predict the round outcome, press Center and wait for the scoreboard to drain.
  task automatic doMatch(input int p1, input int p2);
    exp_t e;
    if (p1 > p2) begin
      e.mr = 1;
      expWin++;
    end else if (p1 < p2) begin
      e.mr = 2;
      expLose++;
    end else begin
      e.mr = 3;
    end
    expRound++;
    expP1Used = expP1Used | (1 << p1);
    expP2Used = expP2Used | (1 << p2);
    e.rnd = expRound;
    e.w   = expWin;
    e.l   = expLose;
    e.p1u = expP1Used;
    e.p2u = expP2Used;
    sbQueue.push_back(e);
    press(B_CENTER);
    for (int i = 0; i < 10 && sbQueue.size() != 0; i++) @(negedge clk);
    checkOutput("sb_drain", sbQueue.size(), 0);
    checkOutput("match_state", bus.state, 5);
    checkOutput("match_fin", bus.fin,
                (expWin == 5 || expLose == 5 || expRound == 9) ? 1 : 0);
  endtask

  task automatic playRound(input int p1, input int p2);
    enterCard(B_LEFT, 1 << p1);
    enterCard(B_RIGHT, 1 << p2);
    doMatch(p1, p2);
  endtask

  // Leave MATCH back to RASP and then to BAWP for the next round.
  task automatic nextRound();
    press(B_LEFT);
    checkOutput("rasp_state", bus.state, 1);
    checkOutput("rasp_matchresult", bus.matchresult, 0);
    checkOutput("rasp_p1_valid", bus.p1_valid, 0);
    press(B_TOP);
  endtask

  // Scoreboard: every score-update pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (!reset && bus.scoreupdate_pulse) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_pulse", 1, 0);
      end else begin
        sbItem = sbQueue.pop_front();
        checkOutput("sb_matchresult", bus.matchresult, sbItem.mr);
        checkOutput("sb_round", bus.round, sbItem.rnd);
        checkOutput("sb_win", bus.win, sbItem.w);
        checkOutput("sb_lose", bus.lose, sbItem.l);
        checkOutput("sb_p1_used", bus.p1_used, sbItem.p1u);
        checkOutput("sb_p2_used", bus.p2_used, sbItem.p2u);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    failCount  = 0;
    resetModel();
    reset = 1'b1;
    {bus.btnBottom, bus.btnCenter, bus.btnTop, bus.btnLeft, bus.btnRight} = 5'b0;
    bus.sw = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_state", bus.state, 0);
    checkOutput("rst_round", bus.round, 0);
    checkOutput("rst_win", bus.win, 0);
    checkOutput("rst_p1_used", bus.p1_used, 0);
    checkOutput("rst_fin", bus.fin, 0);
    checkOutput("rst_pulse", bus.scoreupdate_pulse, 0);
    checkOutput("rst_gameresult", bus.gameresult, 0);
    reset = 1'b0;

    // Early win: p1 always higher, game ends after five rounds.
    press(B_CENTER);
    checkOutput("init_to_rasp", bus.state, 1);
    press(B_TOP);
    checkOutput("rasp_to_bawp", bus.state, 2);
    for (int i = 0; i < 5; i++) begin
      playRound(8 - i, 4 - i);
      if (i < 4) nextRound();
    end
    checkOutput("early_win", bus.win, 5);
    checkOutput("early_round", bus.round, 5);
    checkOutput("early_fin", bus.fin, 1);
    press(B_LEFT);
    checkOutput("early_game_state", bus.state, 6);
    checkOutput("early_gameresult", bus.gameresult, 1);
    press(B_CENTER);
    checkOutput("game_hold_state", bus.state, 6);
    checkOutput("game_hold_round", bus.round, 5);

    // Soft reset, then invalid entries and the guarded match.
    press(B_BOTTOM);
    resetModel();
    checkOutput("soft_state", bus.state, 0);
    checkOutput("soft_round", bus.round, 0);
    checkOutput("soft_p1_used", bus.p1_used, 0);
    press(B_CENTER);
    press(B_TOP);
    playRound(2, 5);
    nextRound();
    enterCard(B_LEFT, 16'h0003);
    checkOutput("inv_two_hot_valid", bus.p1_valid, 0);
    checkOutput("inv_two_hot_used", bus.p1_used, 9'h004);
    checkOutput("inv_two_hot_state", bus.state, 2);
    enterCard(B_LEFT, 16'h0000);
    checkOutput("inv_zero_valid", bus.p1_valid, 0);
    enterCard(B_LEFT, 1 << 2);
    checkOutput("inv_reused_valid", bus.p1_valid, 0);
    checkOutput("inv_reused_used", bus.p1_used, 9'h004);
    enterCard(B_LEFT, 1 << 7);
    checkOutput("p1_valid_set", bus.p1_valid, 1);
    checkOutput("p1_card_set", bus.p1_card, 7);
    press(B_CENTER);
    checkOutput("guard_state", bus.state, 2);
    checkOutput("guard_round", bus.round, 1);

    // Priority and hold: Top+Left held in P1_TURN gives one move to BAWP.
    press(B_LEFT);
    checkOutput("p1_turn_state", bus.state, 3);
    setSwitch(1 << 1);
    applyStimulus(B_TOP | B_LEFT, 5);
    setSwitch(0);
    checkOutput("hold_state", bus.state, 2);
    checkOutput("hold_p1_card", bus.p1_card, 1);
    enterCard(B_RIGHT, 1 << 6);
    doMatch(1, 6);
    press(B_BOTTOM | B_CENTER);
    resetModel();
    checkOutput("prio_state", bus.state, 0);
    checkOutput("prio_round", bus.round, 0);
    checkOutput("prio_p2_used", bus.p2_used, 0);

    // Full draw: nine equal rounds.
    press(B_CENTER);
    press(B_TOP);
    for (int i = 0; i < 9; i++) begin
      playRound(i, i);
      if (i < 8) nextRound();
    end
    checkOutput("draw_round", bus.round, 9);
    checkOutput("draw_win", bus.win, 0);
    checkOutput("draw_lose", bus.lose, 0);
    checkOutput("draw_fin", bus.fin, 1);
    press(B_LEFT);
    checkOutput("draw_game_state", bus.state, 6);
    checkOutput("draw_gameresult", bus.gameresult, 3);

    // Asynchronous reset mid-game in P2_TURN after three rounds.
    press(B_BOTTOM);
    resetModel();
    press(B_CENTER);
    press(B_TOP);
    for (int i = 0; i < 3; i++) begin
      playRound(i + 3, i);
      nextRound();
    end
    press(B_RIGHT);
    checkOutput("pre_reset_state", bus.state, 4);
    checkOutput("pre_reset_round", bus.round, 3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_state", bus.state, 0);
    checkOutput("async_round", bus.round, 0);
    checkOutput("async_win", bus.win, 0);
    checkOutput("async_lose", bus.lose, 0);
    checkOutput("async_p1_used", bus.p1_used, 0);
    checkOutput("async_p2_used", bus.p2_used, 0);
    checkOutput("async_pulse", bus.scoreupdate_pulse, 0);
    resetModel();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
